// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter.
// The default widths follow a 32-register, 32-bit integer file.
package rf_arb_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_REG_W  = 5;
  localparam int RF_NREGS  = 2 ** RF_REG_W;

  localparam logic [RF_REG_W-1:0] REG_ZERO = {RF_REG_W{1'b0}};

  // addr sits in the MSBs so a FIFO tag view of the top bits yields the destination
  typedef struct packed {
    logic [RF_REG_W-1:0]  addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

  function automatic logic [RF_NREGS-1:0] onehot(input logic [RF_REG_W-1:0] idx);
    logic [RF_NREGS-1:0] vec;
    vec      = {RF_NREGS{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_sync_fifo.sv
// Generic synchronous FIFO with a registered occupancy count.
// Also exposes per-slot valid bits and the top TAG_W bits of every slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int TAG_W = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0][TAG_W-1:0] tags,
  output logic [DEPTH-1:0]            entry_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]            wr_ptr_r;
  logic [PTR_W-1:0]            rd_ptr_r;
  logic [CNT_W-1:0]            count_r;
  logic [DEPTH-1:0][WIDTH-1:0] mem_r;
  logic                        push_ok_s;
  logic                        pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is not reset; validity comes from the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PTR_W-1:0] offs_s;
    assign offs_s         = PTR_W'(g) - rd_ptr_r;
    assign entry_valid[g] = ({1'b0, offs_s} < count_r);
    assign tags[g]        = mem_r[g][WIDTH-1 -: TAG_W];
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback (priority) and a
// long-latency unit whose results queue and drain into idle writeback slots.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int REG_W      = RF_REG_W,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we_i,
  input  logic [REG_W-1:0]      wb_waddr_i,
  input  logic [DATA_W-1:0]     wb_wdata_i,
  input  logic                  lu_valid_i,
  output logic                  lu_ready_o,
  input  logic [REG_W-1:0]      lu_waddr_i,
  input  logic [DATA_W-1:0]     lu_wdata_i,
  output logic                  stall_o,
  output logic                  rf_we_o,
  output logic [REG_W-1:0]      rf_waddr_o,
  output logic [DATA_W-1:0]     rf_wdata_o,
  output logic [2**REG_W-1:0]   pending_o
);

  localparam int NREGS    = 2 ** REG_W;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  rf_wr_t                         push_ent_s;
  rf_wr_t                         head_s;
  logic                           full_s;
  logic                           empty_s;
  logic [FIFO_DEPTH-1:0][REG_W-1:0] tags_s;
  logic [FIFO_DEPTH-1:0]          entry_valid_s;
  logic                           wb_busy_s;
  logic                           push_s;
  logic                           pop_s;
  logic [NREGS-1:0]               pending_s;
  logic [STARVE_W-1:0]            starve_r;

  assign wb_busy_s  = wb_we_i && (wb_waddr_i != REG_ZERO);
  assign lu_ready_o = !full_s && !rst;
  // Writes to x0 complete the handshake but are dropped here.
  assign push_s     = lu_valid_i && lu_ready_o && (lu_waddr_i != REG_ZERO);
  assign stall_o    = !rst && !empty_s && wb_busy_s && (starve_r == STARVE_W'(STARVE_MAX));
  assign pop_s      = !rst && !empty_s && (!wb_busy_s || stall_o);
  assign push_ent_s = '{addr: lu_waddr_i, data: lu_wdata_i};

  sync_fifo #(
    .WIDTH (REG_W + DATA_W),
    .DEPTH (FIFO_DEPTH),
    .TAG_W (REG_W)
  ) u_lu_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .pop         (pop_s),
    .wdata       (push_ent_s),
    .rdata       (head_s),
    .full        (full_s),
    .empty       (empty_s),
    .tags        (tags_s),
    .entry_valid (entry_valid_s)
  );

  // Write-port mux: a retiring queue head overrides the writeback request.
  always_comb begin
    if (pop_s) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = head_s.addr;
      rf_wdata_o = head_s.data;
    end else begin
      rf_we_o    = wb_busy_s && !rst;
      rf_waddr_o = wb_waddr_i;
      rf_wdata_o = wb_wdata_i;
    end
  end

  // Age of the current head in cycles it has been denied the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_r <= {STARVE_W{1'b0}};
    end else if (pop_s || empty_s) begin
      starve_r <= {STARVE_W{1'b0}};
    end else if (starve_r != STARVE_W'(STARVE_MAX)) begin
      starve_r <= starve_r + 1'b1;
    end else begin
      starve_r <= starve_r;
    end
  end

  // Destinations of all queued results, for decode hazard checks.
  always_comb begin
    pending_s = {NREGS{1'b0}};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pending_s = pending_s | (onehot(tags_s[i]) & {NREGS{entry_valid_s[i]}});
    end
  end

  assign pending_o = rst ? {NREGS{1'b0}} : {pending_s[NREGS-1:1], 1'b0};

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, corner
// sequences, then random traffic against a queue-based reference model.
module tb_rf_write_arbiter;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_we_i;
  logic [RW-1:0] wb_waddr_i;
  logic [DW-1:0] wb_wdata_i;
  logic          lu_valid_i;
  logic          lu_ready_o;
  logic [RW-1:0] lu_waddr_i;
  logic [DW-1:0] lu_wdata_i;
  logic          stall_o;
  logic          rf_we_o;
  logic [RW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic [31:0]   pending_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .DATA_W(DW), .REG_W(RW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we_i    (wb_we_i),
    .wb_waddr_i (wb_waddr_i),
    .wb_wdata_i (wb_wdata_i),
    .lu_valid_i (lu_valid_i),
    .lu_ready_o (lu_ready_o),
    .lu_waddr_i (lu_waddr_i),
    .lu_wdata_i (lu_wdata_i),
    .stall_o    (stall_o),
    .rf_we_o    (rf_we_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o),
    .pending_o  (pending_o)
  );

  typedef struct {
    string       name;
    logic        r, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        es, er, ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] ep;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];
  int   mcnt;
  logic hold;

  function automatic logic [31:0] b(input int r);
    return 32'd1 << r;
  endfunction

  function automatic vec_t mk(input string n, input logic r, we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic lv, input logic [4:0] la,
                              input logic [31:0] ld, input logic es, er, ewe,
                              input logic [4:0] ea, input logic [31:0] ed, input logic [31:0] ep);
    vec_t v;
    v.name = n; v.r = r; v.we = we; v.wa = wa; v.wd = wd; v.lv = lv; v.la = la; v.ld = ld;
    v.es = es; v.er = er; v.ewe = ewe; v.ea = ea; v.ed = ed; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    rst = r; wb_we_i = we; wb_waddr_i = wa; wb_wdata_i = wd;
    lu_valid_i = lv; lu_waddr_i = la; lu_wdata_i = ld;
  endtask

  // Inputs change at negedge; outputs are sampled 2ns later, well before posedge.
  task automatic expect_cyc(input string name, input logic es, er, ewe,
                            input logic [4:0] ea, input logic [31:0] ed, input logic [31:0] ep);
    #2;
    chk({name, ".stall"},   64'(stall_o),    64'(es));
    chk({name, ".ready"},   64'(lu_ready_o), 64'(er));
    chk({name, ".we"},      64'(rf_we_o),    64'(ewe));
    chk({name, ".pending"}, 64'(pending_o),  64'(ep));
    if (ewe) begin
      chk({name, ".waddr"}, 64'(rf_waddr_o), 64'(ea));
      chk({name, ".wdata"}, 64'(rf_wdata_o), 64'(ed));
    end
    @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);

    // name, rst, wb_we, wb_a, wb_d, lu_v, lu_a, lu_d | stall, ready, we, a, d, pending
    tbl.push_back(mk("rst",        1'b1, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    32'h0));
    tbl.push_back(mk("wb_x5",      1'b0, 1'b1, 5'd5,  32'hA5, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 5'd5,  32'hA5,   32'h0));
    tbl.push_back(mk("push_x7",    1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 5'd7,  32'h1234, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h0));
    tbl.push_back(mk("ret_x7",     1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 5'd7,  32'h1234, b(7)));
    tbl.push_back(mk("clr_x7",     1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h0));
    tbl.push_back(mk("push_x10",   1'b0, 1'b1, 5'd3,  32'h3,  1'b1, 5'd10, 32'hA,    1'b0, 1'b1, 1'b1, 5'd3,  32'h3,    32'h0));
    tbl.push_back(mk("push_x11",   1'b0, 1'b1, 5'd3,  32'h3,  1'b1, 5'd11, 32'hB,    1'b0, 1'b1, 1'b1, 5'd3,  32'h3,    b(10)));
    tbl.push_back(mk("full_hold",  1'b0, 1'b1, 5'd3,  32'h3,  1'b1, 5'd13, 32'hD,    1'b0, 1'b0, 1'b1, 5'd3,  32'h3,    b(10) | b(11)));
    tbl.push_back(mk("ret_x10",    1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 5'd13, 32'hD,    1'b0, 1'b0, 1'b1, 5'd10, 32'hA,    b(10) | b(11)));
    tbl.push_back(mk("push_x13",   1'b0, 1'b1, 5'd3,  32'h3,  1'b1, 5'd13, 32'hD,    1'b0, 1'b1, 1'b1, 5'd3,  32'h3,    b(11)));
    tbl.push_back(mk("ret_x11",    1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b1, 5'd11, 32'hB,    b(11) | b(13)));
    tbl.push_back(mk("ret_x13",    1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 5'd13, 32'hD,    b(13)));
    tbl.push_back(mk("drained",    1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h0));
    tbl.push_back(mk("lu_x0",      1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 5'd0,  32'hDEAD, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h0));
    tbl.push_back(mk("x0_none",    1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h0));
    tbl.push_back(mk("push_x12",   1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 5'd12, 32'hC,    1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h0));
    tbl.push_back(mk("wb0_ret12",  1'b0, 1'b1, 5'd0,  32'h99, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 5'd12, 32'hC,    b(12)));
    tbl.push_back(mk("after12",    1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd0,  32'h0,    32'h0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].lv, tbl[i].la, tbl[i].ld);
      expect_cyc(tbl[i].name, tbl[i].es, tbl[i].er, tbl[i].ewe, tbl[i].ea, tbl[i].ed, tbl[i].ep);
    end

    // Starvation: x9 queued at t, writeback hammers x3.
    drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'hBEEF);
    expect_cyc("st_t", 1'b0, 1'b1, 1'b1, 5'd3, 32'h33, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
      expect_cyc($sformatf("st_t%0d", k), 1'b0, 1'b1, 1'b1, 5'd3, 32'h33, b(9));
    end
    drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    expect_cyc("st_t5", 1'b1, 1'b1, 1'b1, 5'd9, 32'hBEEF, b(9));
    expect_cyc("st_t6", 1'b0, 1'b1, 1'b1, 5'd3, 32'h33, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_cyc("st_idle", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);

    // Reset with two results queued: they must vanish.
    drive(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd20, 32'h14);
    expect_cyc("rs_push20", 1'b0, 1'b1, 1'b1, 5'd3, 32'h3, 32'h0);
    drive(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd21, 32'h15);
    expect_cyc("rs_push21", 1'b0, 1'b1, 1'b1, 5'd3, 32'h3, b(20));
    drive(1'b1, 1'b1, 5'd3, 32'h3, 1'b1, 5'd22, 32'h16);
    expect_cyc("rs_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_cyc("rs_after", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    expect_cyc("rs_after2", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);

    // Random traffic; wb uses x0..x15 and LU uses x0/x16..x31 so decode's
    // no-WAW contract holds by construction.
    mq.delete();
    mcnt = 0;
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic        busy, m_ready, m_stall, m_pop, m_we, was_empty;
      logic [4:0]  m_a;
      logic [31:0] m_d, m_pend;
      rst = ($urandom_range(0, 149) == 0) || (i == 0);
      if (!hold) begin
        wb_we_i    = ($urandom_range(0, 3) != 0);
        wb_waddr_i = 5'($urandom_range(0, 15));
        wb_wdata_i = $urandom;
      end
      lu_valid_i = ($urandom_range(0, 1) != 0);
      lu_waddr_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
      lu_wdata_i = $urandom;

      busy   = wb_we_i && (wb_waddr_i != 5'd0);
      m_pend = 32'h0;
      foreach (mq[k]) m_pend = m_pend | b(mq[k].a);
      if (rst) begin
        m_ready = 1'b0; m_stall = 1'b0; m_pop = 1'b0; m_we = 1'b0;
        m_a = 5'd0; m_d = 32'h0; m_pend = 32'h0;
      end else begin
        m_ready = (mq.size() < DEPTH);
        m_stall = (mq.size() > 0) && busy && (mcnt == SMAX);
        m_pop   = (mq.size() > 0) && (!busy || m_stall);
        m_we    = m_pop || busy;
        m_a     = m_pop ? mq[0].a : wb_waddr_i;
        m_d     = m_pop ? mq[0].d : wb_wdata_i;
      end

      #2;
      chk("rnd.stall",   64'(stall_o),    64'(m_stall));
      chk("rnd.ready",   64'(lu_ready_o), 64'(m_ready));
      chk("rnd.we",      64'(rf_we_o),    64'(m_we));
      chk("rnd.pending", 64'(pending_o),  64'(m_pend));
      if (m_we) begin
        chk("rnd.waddr", 64'(rf_waddr_o), 64'(m_a));
        chk("rnd.wdata", 64'(rf_wdata_o), 64'(m_d));
      end
      if (!rst) chk("rnd.contract", 64'(pending_o[wb_waddr_i] & busy), 64'(0));

      if (rst) begin
        mq.delete();
        mcnt = 0;
        hold = 1'b0;
      end else begin
        was_empty = (mq.size() == 0);
        if (m_pop) void'(mq.pop_front());
        if (lu_valid_i && m_ready && (lu_waddr_i != 5'd0))
          mq.push_back('{a: lu_waddr_i, d: lu_wdata_i});
        mcnt = (m_pop || was_empty) ? 0 : ((mcnt < SMAX) ? mcnt + 1 : SMAX);
        hold = m_stall;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
